// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller:
//   state encoding, opcode/funct constants, datapath mux codes,
//   decoded instruction-class bundle, control bundle and EXE ALU/ext helper.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_BR  = 3'd5,
    S_JMP = 3'd6
  } state_e;

  localparam int unsigned OP_W = 6;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_JR   = 6'h08;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;

  // aluctr
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b11;

  // extop
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // pcsrc
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  // regdst
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // memtoreg
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
  localparam logic [1:0] M2R_SLT = 2'b11;

  // alusrc_b
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // One-hot instruction class; all-zero means unrecognised.
  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic j;
    logic jal;
    logic beq;
    logic addi;
    logic addiu;
    logic ori;
    logic lw;
    logic sw;
    logic lui;
  } instr_class_t;

  // Datapath control bundle driven by the FSM.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pcsrc;
    logic       reg_write;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluctr;
    logic [1:0] extop;
    logic       illegal;
    logic       ovf_err;
  } ctl_t;

  function automatic logic is_rtype_arith(input instr_class_t c);
    return c.addu | c.subu | c.slt;
  endfunction

  // EXE-stage {aluctr, extop}, same encoding as the single-cycle datapath.
  function automatic logic [3:0] exe_alu_ctl(input instr_class_t c);
    logic [1:0] alu;
    logic [1:0] ext;
    alu = ALU_ADD;
    ext = EXT_ZERO;
    if (c.subu || c.slt) alu = ALU_SUB;
    if (c.addiu || c.lw || c.sw) ext = EXT_SIGN;
    if (c.addi) begin
      alu = ALU_ADDI;
      ext = EXT_SIGN;
    end
    if (c.ori) alu = ALU_OR;
    if (c.lui) begin
      alu = ALU_OR;
      ext = EXT_LUI;
    end
    return {alu, ext};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder.
//   op      in  6   ins[31:26]
//   funct   in  6   ins[5:0]
//   cls     out     one-hot instruction class
//   illegal out 1   no supported opcode/funct matched
module mc_decode
  import mc_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  output instr_class_t    cls,
  output logic            illegal
);

  logic rtype;
  assign rtype = (op == OP_RTYPE);

  always_comb begin
    cls       = '0;
    cls.addu  = rtype && (funct == FN_ADDU);
    cls.subu  = rtype && (funct == FN_SUBU);
    cls.slt   = rtype && (funct == FN_SLT);
    cls.jr    = rtype && (funct == FN_JR);
    cls.j     = (op == OP_J);
    cls.jal   = (op == OP_JAL);
    cls.beq   = (op == OP_BEQ);
    cls.addi  = (op == OP_ADDI);
    cls.addiu = (op == OP_ADDIU);
    cls.ori   = (op == OP_ORI);
    cls.lw    = (op == OP_LW);
    cls.sw    = (op == OP_SW);
    cls.lui   = (op == OP_LUI);
  end

  assign illegal = (cls == '0);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM IF/ID/EXE/MEM/WB/BR/JMP
// over a shared memory and ALU, with memory handshake or fixed latency,
// addi overflow trap, illegal-op pulse and retired-instruction counter.
//   clk, reset (sync, active-high)
//   ins, mem_ready, alu_zero, alu_ovf                 inputs
//   mem_req mem_we iord ir_write pc_write pcsrc       memory / PC control
//   reg_write regdst memtoreg alusrc_a alusrc_b       register file / ALU muxes
//   aluctr extop                                      ALU op / immediate extend
//   state_o illegal ovf_err retire_cnt                status
// All outputs are forced to 0 while reset is high.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_LAT       = 1,
  parameter bit          ADDI_TRAP     = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             mem_ready,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pcsrc,
  output logic             reg_write,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluctr,
  output logic [1:0]       extop,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic             ovf_err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             done;
  logic             retire;
  logic             ovf_trap;
  instr_class_t     cls;
  logic             dec_illegal;
  ctl_t             ctl, ctl_out;

  // Only opcode and funct steer control; the register/immediate fields do not.
  logic unused_ins_bits;
  assign unused_ins_bits = ^ins[25:6];

  mc_decode u_decode (
    .op      (ins[31:26]),
    .funct   (ins[5:0]),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // Memory access completes this cycle.
  assign done = MEM_HANDSHAKE ? mem_ready : (lat_cnt == LAT_W'(MEM_LAT - 1));

  // Latency counter runs only while waiting in IF/MEM.
  assign lat_nxt = (((state == S_IF) || (state == S_MEM)) && !done) ?
                   lat_cnt + LAT_W'(1) : '0;

  // An instruction retires when control returns to IF from any completing state.
  assign retire = (state_nxt == S_IF) &&
                  ((state == S_MEM) || (state == S_WB) || (state == S_BR) || (state == S_JMP));

  // State, latency and retire counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      lat_cnt <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    ovf_trap  = 1'b0;
    case (state)
      S_IF: begin
        ctl.mem_req  = 1'b1;
        ctl.iord     = 1'b0;
        ctl.alusrc_a = 1'b0;
        ctl.alusrc_b = SRCB_FOUR;
        ctl.aluctr   = ALU_ADD;
        ctl.pcsrc    = PC_ALU;
        ctl.ir_write = done;
        ctl.pc_write = done;
        if (done) state_nxt = S_ID;
      end
      S_ID: begin
        // Precompute branch target into ALUOut.
        ctl.alusrc_a = 1'b0;
        ctl.alusrc_b = SRCB_BRANCH;
        ctl.aluctr   = ALU_ADD;
        ctl.extop    = EXT_SIGN;
        if (cls.beq) begin
          state_nxt = S_BR;
        end else if (cls.j || cls.jal || cls.jr) begin
          state_nxt = S_JMP;
        end else if (dec_illegal) begin
          ctl.illegal = 1'b1;
          state_nxt   = S_IF;
        end else begin
          state_nxt = S_EXE;
        end
      end
      S_EXE: begin
        ctl.alusrc_a              = 1'b1;
        ctl.alusrc_b              = is_rtype_arith(cls) ? SRCB_RT : SRCB_IMM;
        {ctl.aluctr, ctl.extop}   = exe_alu_ctl(cls);
        state_nxt                 = (cls.lw || cls.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_we  = cls.sw;
        if (done) state_nxt = cls.sw ? S_IF : S_WB;
      end
      S_WB: begin
        ovf_trap      = ADDI_TRAP && cls.addi && alu_ovf;
        ctl.reg_write = !ovf_trap;
        ctl.ovf_err   = ovf_trap;
        ctl.regdst    = is_rtype_arith(cls) ? RD_RD : RD_RT;
        ctl.memtoreg  = cls.lw ? M2R_MDR : (cls.slt ? M2R_SLT : M2R_ALU);
        state_nxt     = S_IF;
      end
      S_BR: begin
        ctl.alusrc_a = 1'b1;
        ctl.alusrc_b = SRCB_RT;
        ctl.aluctr   = ALU_SUB;
        ctl.pcsrc    = PC_ALUOUT;
        ctl.pc_write = alu_zero;
        state_nxt    = S_IF;
      end
      S_JMP: begin
        ctl.pc_write = 1'b1;
        ctl.pcsrc    = cls.jr ? PC_RS : PC_JUMP;
        if (cls.jal) begin
          // PC already holds the return address (PC+4).
          ctl.reg_write = 1'b1;
          ctl.regdst    = RD_RA;
          ctl.memtoreg  = M2R_PC;
        end
        state_nxt = S_IF;
      end
      default: begin
        state_nxt = S_IF;
      end
    endcase
  end

  // Reset blanks every output.
  assign ctl_out    = reset ? '0 : ctl;
  assign state_o    = reset ? 3'd0 : state;
  assign retire_cnt = reset ? '0 : cnt_q;

  assign mem_req   = ctl_out.mem_req;
  assign mem_we    = ctl_out.mem_we;
  assign iord      = ctl_out.iord;
  assign ir_write  = ctl_out.ir_write;
  assign pc_write  = ctl_out.pc_write;
  assign pcsrc     = ctl_out.pcsrc;
  assign reg_write = ctl_out.reg_write;
  assign regdst    = ctl_out.regdst;
  assign memtoreg  = ctl_out.memtoreg;
  assign alusrc_a  = ctl_out.alusrc_a;
  assign alusrc_b  = ctl_out.alusrc_b;
  assign aluctr    = ctl_out.aluctr;
  assign extop     = ctl_out.extop;
  assign illegal   = ctl_out.illegal;
  assign ovf_err   = ctl_out.ovf_err;

endmodule
